postadder: RTL and testbench



---
 rtl/fp_pkg.sv | 24 ++
 rtl/round_pack.sv | 45 ++++
 rtl/postadder.sv | 116 +++++++++++
 tb/tb_postadder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision adder definitions.
// Holds binary32 field constants, the bit layout of the 28-bit aligned mantissa sum
// and the post-adder FSM state type. Also used by the pre-adder special-case logic.
package fp_pkg;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    // Bit positions inside the 28-bit mantissa sum.
    localparam int unsigned CARRY_BIT  = 27;
    localparam int unsigned HIDDEN_BIT = 26;
    localparam int unsigned LSB_BIT    = 3;
    localparam int unsigned GUARD_BIT  = 2;
    localparam int unsigned ROUND_BIT  = 1;
    localparam int unsigned STICKY_BIT = 0;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } post_state_t;

endpackage

// File: rtl/round_pack.sv
// Round-to-nearest-even, post-round renormalize, overflow check and binary32 pack.
// Purely combinational.
//   sign_i   : result sign
//   mant_i   : normalized mantissa, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky
//   exp_i    : biased exponent (wide so an exponent past 255 is still visible)
//   result_o : packed binary32 word
module round_pack
    import fp_pkg::*;
(
    input  logic        sign_i,
    input  logic [26:0] mant_i,
    input  logic [9:0]  exp_i,
    output logic [31:0] result_o
);

    logic        inc;
    logic [24:0] mant_r;
    logic [9:0]  exp_r;
    logic [22:0] frac;

    always_comb begin
        inc    = mant_i[GUARD_BIT] &
                 (mant_i[ROUND_BIT] | mant_i[STICKY_BIT] | mant_i[LSB_BIT]);
        mant_r = {1'b0, mant_i[HIDDEN_BIT:LSB_BIT]} + {24'd0, inc};
        exp_r  = exp_i;
        frac   = mant_r[22:0];

        if (mant_r[24]) begin
            // Increment carried out of the hidden bit: the mantissa is 1.000..., bump exp.
            exp_r = exp_i + 10'd1;
            frac  = mant_r[23:1];
        end else if (!mant_r[23]) begin
            // Still no hidden bit: subnormal, exponent field is 0. A subnormal that rounds
            // up into the hidden bit keeps exp_i (which is 1) and so becomes normal.
            exp_r = 10'd0;
        end

        if (exp_r >= {2'b00, EXP_MAX}) begin
            result_o = {sign_i, EXP_MAX, 23'd0};
        end else begin
            result_o = {sign_i, exp_r[7:0], frac};
        end
    end

endmodule

// File: rtl/postadder.sv
// Back end of the single-precision adder: normalize, round, pack.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready is a state decode)
//   sign, exp         : result sign and common biased exponent
//   mantis_sum        : 28-bit aligned sum {carry, hidden, frac[22:0], guard, round, sticky}
//   special_result    : precomputed NaN/Inf/zero result, used when special_case is high
//   out_valid/out_ready, result : output handshake and packed binary32 word
module postadder
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [27:0] mantis_sum,
    input  logic [31:0] special_result,
    input  logic        special_case,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    post_state_t state_q, state_d;
    logic [27:0] m_q, m_d;
    logic [9:0]  e_q, e_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;
    logic [31:0] rounded;

    round_pack u_round_pack (
        .sign_i   (sign_q),
        .mant_i   (m_q[26:0]),
        .exp_i    (e_q),
        .result_o (rounded)
    );

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        sign_d   = sign_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = sign;
                    m_d    = mantis_sum;
                    e_d    = {2'b00, exp};
                    if (special_case) begin
                        result_d = special_result;
                        state_d  = StDone;
                    end else if (mantis_sum == 28'd0) begin
                        result_d = {sign, 31'd0};
                        state_d  = StDone;
                    end else if (mantis_sum[CARRY_BIT] ||
                                 (!mantis_sum[HIDDEN_BIT] && exp > 8'd1)) begin
                        state_d = StNorm;
                    end else begin
                        // Already normalized (or subnormal at exp 1): nothing to shift.
                        state_d = StRound;
                    end
                end
            end
            StNorm: begin
                if (m_q[CARRY_BIT]) begin
                    // Shifted-out bit folds into sticky.
                    m_d     = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
                    e_d     = e_q + 10'd1;
                    state_d = StRound;
                end else begin
                    m_d = {m_q[26:0], 1'b0};
                    e_d = e_q - 10'd1;
                    // Look ahead so the last shift also moves on to ROUND: stop when the
                    // shifted value has its hidden bit or the exponent reaches 1.
                    if (m_q[HIDDEN_BIT-1] || e_q <= 10'd2) begin
                        state_d = StRound;
                    end
                end
            end
            StRound: begin
                result_d = rounded;
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            m_q      <= 28'd0;
            e_q      <= 10'd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            e_q      <= e_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;

endmodule

// File: tb/tb_postadder.sv
module tb_postadder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [27:0] mantis_sum;
    logic [31:0] special_result;
    logic        special_case;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    postadder dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sign           (sign_in),
        .exp            (exp_in),
        .mantis_sum     (mantis_sum),
        .special_result (special_result),
        .special_case   (special_case),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one bundle, wait (bounded) for out_valid, return result and latency.
    task automatic do_op(input string tag, input logic s, input logic [7:0] e,
                         input logic [27:0] m, input logic sc, input logic [31:0] sr,
                         output logic [31:0] res, output int lat);
        in_valid       = 1'b1;
        sign_in        = s;
        exp_in         = e;
        mantis_sum     = m;
        special_case   = sc;
        special_result = sr;
        step();
        in_valid     = 1'b0;
        special_case = 1'b0;
        lat          = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        res = result;
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid_low"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                           input logic [27:0] m, input logic [31:0] want, input int want_lat);
        logic [31:0] res;
        int          lat;
        do_op(tag, s, e, m, 1'b0, 32'd0, res, lat);
        check({tag, "_result"}, res, want);
        check({tag, "_latency"}, lat, want_lat);
        release_out(tag);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;

        rst            = 1'b1;
        in_valid       = 1'b0;
        sign_in        = 1'b0;
        exp_in         = 8'd0;
        mantis_sum     = 28'd0;
        special_result = 32'd0;
        special_case   = 1'b0;
        out_ready      = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);

        run_vec("carry",     1'b0, 8'd127, 28'h800_0000, 32'h4000_0000, 3);
        run_vec("cancel",    1'b0, 8'd127, 28'h100_0000, 32'h3E80_0000, 4);
        run_vec("rne_tie",   1'b0, 8'd127, 28'h400_0004, 32'h3F80_0000, 2);
        run_vec("rne_up",    1'b0, 8'd127, 28'h400_000C, 32'h3F80_0002, 2);
        run_vec("rnd_carry", 1'b0, 8'd127, 28'h7FF_FFFC, 32'h4000_0000, 2);
        run_vec("overflow",  1'b1, 8'd254, 28'h800_0000, 32'hFF80_0000, 3);
        run_vec("subnormal", 1'b0, 8'd2,   28'h100_0000, 32'h0040_0000, 3);
        run_vec("sub_to_nrm", 1'b0, 8'd1,  28'h3FF_FFFC, 32'h0080_0000, 2);
        run_vec("zero",      1'b1, 8'd100, 28'h000_0000, 32'h8000_0000, 1);

        // Special bypass with backpressure.
        do_op("special", 1'b0, 8'd0, 28'h123_4567, 1'b1, 32'h7FC0_0000, res, lat);
        check("special_result", res, 32'h7FC0_0000);
        check("special_latency", lat, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_result", result, 32'h7FC0_0000);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        release_out("special_rel");

        // Reset in the middle of a long shift loop.
        in_valid   = 1'b1;
        sign_in    = 1'b0;
        exp_in     = 8'd127;
        mantis_sum = 28'h000_0008;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("norm_busy_in_ready", {31'd0, in_ready}, 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 30; i++) begin
            step();
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_vec("after_rst", 1'b0, 8'd127, 28'h400_0000, 32'h3F80_0000, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
